// File: rtl/instr_fetch_unit_if.sv
// Purpose: bundles the fetch unit's bus-facing signals: downstream control
// (stall/redirect), the instruction-memory req/gnt/rvalid channel, and the
// fetch/decode output (pc, instr, valid, flush).
// Modports: master = fetch unit side, slave = environment (memory + pipeline).
interface instr_fetch_unit_if #(
  parameter int unsigned BIT_WIDTH = 32
);
  logic                 i_stall;
  logic                 i_redirect;
  logic [BIT_WIDTH-1:0] i_redirect_pc;
  logic                 o_imem_req;
  logic [BIT_WIDTH-1:0] o_imem_addr;
  logic                 i_imem_gnt;
  logic                 i_imem_rvalid;
  logic [BIT_WIDTH-1:0] i_imem_rdata;
  logic [BIT_WIDTH-1:0] o_pc;
  logic [BIT_WIDTH-1:0] o_instr;
  logic                 o_valid;
  logic                 o_flush;

  modport master (
    input  i_stall, i_redirect, i_redirect_pc, i_imem_gnt, i_imem_rvalid, i_imem_rdata,
    output o_imem_req, o_imem_addr, o_pc, o_instr, o_valid, o_flush
  );

  modport slave (
    output i_stall, i_redirect, i_redirect_pc, i_imem_gnt, i_imem_rvalid, i_imem_rdata,
    input  o_imem_req, o_imem_addr, o_pc, o_instr, o_valid, o_flush
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Purpose: fetch-side producer. Owns the PC, issues in-order word requests to
// instruction memory, buffers returned {pc,instr} pairs for decode, and on a
// redirect discards wrong-path state and flushes the fetch/decode register.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   bus (master)     i_stall/i_redirect/i_redirect_pc from the pipeline,
//                    o_imem_req/o_imem_addr/i_imem_gnt/i_imem_rvalid/i_imem_rdata
//                    to instruction memory, o_pc/o_instr/o_valid/o_flush to decode.
module instr_fetch_unit #(
  parameter int unsigned          BIT_WIDTH       = 32,
  parameter logic [BIT_WIDTH-1:0] RESET_PC        = '0,
  parameter int unsigned          MAX_OUTSTANDING = 2,
  parameter int unsigned          OUT_DEPTH       = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  instr_fetch_unit_if.master bus
);

  localparam int unsigned OCW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned BCW = $clog2(OUT_DEPTH + 1);
  localparam int unsigned SCW = $clog2(MAX_OUTSTANDING + OUT_DEPTH + 1);
  localparam logic [BIT_WIDTH-1:0] NOP_INSTR = BIT_WIDTH'(32'h0000_0013);

  typedef struct packed {
    logic [BIT_WIDTH-1:0] pc;
    logic [BIT_WIDTH-1:0] instr;
  } entry_t;

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [BIT_WIDTH-1:0] pc_q, pc_d;
  logic [OCW-1:0]       outst_q, outst_d;
  logic [OCW-1:0]       drop_q, drop_d;
  logic [BCW-1:0]       bcnt_q, bcnt_d;
  logic [BIT_WIDTH-1:0] pend_q [MAX_OUTSTANDING];
  logic [BIT_WIDTH-1:0] pend_d [MAX_OUTSTANDING];
  entry_t               buf_q  [OUT_DEPTH];
  entry_t               buf_d  [OUT_DEPTH];

  logic [OCW-1:0] live_c;
  logic [SCW-1:0] credit_c;
  logic           req_c;
  logic           valid_c;
  logic           issue_c;
  logic           resp_c;
  logic           pop_c;
  logic [OCW-1:0] pend_slot_c;
  logic [BCW-1:0] bcnt_pop_c;
  logic           unused_rpc_lsbs;

  assign unused_rpc_lsbs = ^bus.i_redirect_pc[1:0];

  // Credits: only live (non-stale) outstanding requests reserve a buffer slot,
  // so every buffered response is guaranteed room and rvalid is never stalled.
  assign live_c   = outst_q - drop_q;
  assign credit_c = SCW'(live_c) + SCW'(bcnt_q);
  assign req_c    = !i_rst && (outst_q < OCW'(MAX_OUTSTANDING)) && (credit_c < SCW'(OUT_DEPTH));

  assign valid_c  = (bcnt_q != '0) && !bus.i_redirect && !i_rst;
  assign issue_c  = req_c && bus.i_imem_gnt;
  assign resp_c   = bus.i_imem_rvalid && (outst_q != '0);
  assign pop_c    = valid_c && !bus.i_stall;

  assign bus.o_imem_req  = req_c;
  assign bus.o_imem_addr = pc_q;
  assign bus.o_valid     = valid_c;
  assign bus.o_pc        = valid_c ? buf_q[0].pc : '0;
  assign bus.o_instr     = valid_c ? buf_q[0].instr : NOP_INSTR;
  assign bus.o_flush     = bus.i_redirect && !i_rst;

  // Next-state: pending-address FIFO, output buffer, PC, credits and drain FSM.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    outst_d     = outst_q;
    drop_d      = drop_q;
    bcnt_d      = bcnt_q;
    pend_d      = pend_q;
    buf_d       = buf_q;
    pend_slot_c = outst_q - OCW'(resp_c);
    bcnt_pop_c  = bcnt_q - BCW'(pop_c);

    // Pending FIFO: head leaves on a response, new address appends on issue.
    if (resp_c) begin
      for (int i = 0; i < int'(MAX_OUTSTANDING) - 1; i++) begin
        pend_d[i] = pend_q[i + 1];
      end
    end
    if (issue_c) begin
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        if (OCW'(i) == pend_slot_c) begin
          pend_d[i] = pc_q;
        end
      end
    end
    outst_d = outst_q + OCW'(issue_c) - OCW'(resp_c);

    // Output buffer: pop head first, then append a kept response behind it.
    if (pop_c) begin
      for (int i = 0; i < int'(OUT_DEPTH) - 1; i++) begin
        buf_d[i] = buf_q[i + 1];
      end
    end
    bcnt_d = bcnt_pop_c;
    if (resp_c && (state_q == ST_FETCH)) begin
      for (int i = 0; i < int'(OUT_DEPTH); i++) begin
        if (BCW'(i) == bcnt_pop_c) begin
          buf_d[i].pc    = pend_q[0];
          buf_d[i].instr = bus.i_imem_rdata;
        end
      end
      bcnt_d = bcnt_pop_c + BCW'(1);
    end
    if (resp_c && (state_q == ST_DRAIN)) begin
      drop_d = drop_q - OCW'(1);
    end

    if (issue_c) begin
      pc_d = pc_q + BIT_WIDTH'(4);
    end

    // Redirect: everything still in flight after this cycle is wrong-path,
    // including a request granted in this very cycle.
    if (bus.i_redirect) begin
      pc_d   = {bus.i_redirect_pc[BIT_WIDTH-1:2], 2'b00};
      bcnt_d = '0;
      drop_d = outst_d;
    end

    state_d = (drop_d != '0) ? ST_DRAIN : ST_FETCH;
  end

  // Control state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      outst_q <= '0;
      drop_q  <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Payload storage; validity is tracked by the counters above.
  always_ff @(posedge i_clk) begin
    pend_q <= pend_d;
    buf_q  <= buf_d;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Purpose: self-checking bench for instr_fetch_unit. Directed cycle tables,
// hand-written redirect/reset sequences and randomized traffic checked against
// a queue-based reference model of the fetch unit and an in-order memory.
module tb_instr_fetch_unit;

  localparam int unsigned BW    = 32;
  localparam int unsigned MAXO  = 2;
  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clk;
  logic rst;

  instr_fetch_unit_if #(.BIT_WIDTH(BW)) bus ();

  instr_fetch_unit #(
    .BIT_WIDTH      (BW),
    .RESET_PC       (RST_PC),
    .MAX_OUTSTANDING(MAXO),
    .OUT_DEPTH      (DEPTH)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  typedef struct { logic [31:0] addr; bit stale; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  pend_t       m_pend[$];
  ent_t        m_buf[$];
  logic [31:0] m_pc;
  logic [31:0] mem_q[$];

  logic        s_req, s_valid, s_flush;
  logic [31:0] s_addr, s_pc, s_instr;
  logic        e_req, e_valid, e_flush;
  logic [31:0] e_addr, e_pc, e_instr;
  bit          cur_rst;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_eval(input bit rst_i, input bit redir);
    int live = 0;
    foreach (m_pend[i]) if (!m_pend[i].stale) live++;
    e_req   = !rst_i && (m_pend.size() < int'(MAXO)) && (live + m_buf.size() < int'(DEPTH));
    e_addr  = m_pc;
    e_valid = !rst_i && !redir && (m_buf.size() > 0);
    e_pc    = e_valid ? m_buf[0].pc : 32'h0;
    e_instr = e_valid ? m_buf[0].instr : NOP;
    e_flush = redir && !rst_i;
  endtask

  task automatic model_update(input bit rst_i, input bit stall, input bit redir,
                              input logic [31:0] rpc, input bit gnt, input bit rv,
                              input logic [31:0] rd);
    if (rst_i) begin
      m_pend.delete();
      m_buf.delete();
      mem_q.delete();
      m_pc = RST_PC;
      return;
    end
    if (e_valid && !stall) void'(m_buf.pop_front());
    if (rv && m_pend.size() > 0) begin
      pend_t p;
      p = m_pend.pop_front();
      void'(mem_q.pop_front());
      if (!p.stale) m_buf.push_back('{p.addr, rd});
    end
    if (e_req && gnt) begin
      m_pend.push_back('{m_pc, 1'b0});
      mem_q.push_back(m_pc);
      m_pc = m_pc + 32'd4;
    end
    if (redir) begin
      foreach (m_pend[i]) m_pend[i].stale = 1'b1;
      m_buf.delete();
      m_pc = {rpc[31:2], 2'b00};
    end
  endtask

  // One clock: drive at negedge, sample outputs 1ns later, advance the model.
  task automatic step(input bit rst_i, input bit stall, input bit redir,
                      input logic [31:0] rpc, input bit gnt, input bit rv_en,
                      input bit spur);
    logic        rv;
    logic [31:0] rd;
    @(negedge clk);
    rv = 1'b0;
    rd = $urandom;
    if (!rst_i && rv_en && mem_q.size() > 0) begin
      rv = 1'b1;
      rd = mem_word(mem_q[0]);
    end else if (!rst_i && spur && mem_q.size() == 0) begin
      rv = 1'b1;
    end
    rst               = rst_i;
    bus.i_stall       = stall;
    bus.i_redirect    = redir;
    bus.i_redirect_pc = rpc;
    bus.i_imem_gnt    = gnt;
    bus.i_imem_rvalid = rv;
    bus.i_imem_rdata  = rd;
    #1;
    cur_rst = rst_i;
    s_req   = bus.o_imem_req;
    s_addr  = bus.o_imem_addr;
    s_valid = bus.o_valid;
    s_pc    = bus.o_pc;
    s_instr = bus.o_instr;
    s_flush = bus.o_flush;
    model_eval(rst_i, redir);
    model_update(rst_i, stall, redir, rpc, gnt, rv, rd);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".req"}, 32'(s_req), 32'(e_req));
    if (!cur_rst) check({tag, ".addr"}, s_addr, e_addr);
    check({tag, ".valid"}, 32'(s_valid), 32'(e_valid));
    check({tag, ".pc"}, s_pc, e_pc);
    check({tag, ".instr"}, s_instr, e_instr);
    check({tag, ".flush"}, 32'(s_flush), 32'(e_flush));
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // Free-running fetch after a redirect to tgt: first issued address and first
  // presented pc must be tgt, and nothing outside the new stream may appear.
  task automatic run_after_redirect(input string tag, input logic [31:0] tgt, input int cycles);
    bit seen_req   = 1'b0;
    bit seen_valid = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      check_model(tag);
      if (s_req && !seen_req) begin
        seen_req = 1'b1;
        check({tag, ".first_addr"}, s_addr, tgt);
      end
      if (s_valid) begin
        if (!seen_valid) begin
          seen_valid = 1'b1;
          check({tag, ".first_pc"}, s_pc, tgt);
        end else begin
          check({tag, ".pc_in_stream"}, 32'((s_pc >= tgt) && (s_pc < tgt + 32'h100)), 32'd1);
        end
      end
    end
    check({tag, ".valid_seen_in_budget"}, 32'(seen_valid), 32'd1);
  endtask

  typedef struct {
    bit          rst;
    bit          stall;
    bit          gnt;
    bit          rv;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vt[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst               = 1'b1;
    bus.i_stall       = 1'b0;
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = 32'h0;
    bus.i_imem_gnt    = 1'b0;
    bus.i_imem_rvalid = 1'b0;
    bus.i_imem_rdata  = 32'h0;

    // Streaming with 1-cycle memory, then a stalled downstream.
    vt.push_back('{1, 0, 1, 1, 0, 32'h0,  0, 32'h0});
    vt.push_back('{1, 0, 1, 1, 0, 32'h0,  0, 32'h0});
    vt.push_back('{0, 0, 1, 1, 1, 32'h0,  0, 32'h0});
    vt.push_back('{0, 0, 1, 1, 1, 32'h4,  0, 32'h0});
    vt.push_back('{0, 0, 1, 1, 0, 32'h8,  1, 32'h0});
    vt.push_back('{0, 0, 1, 1, 1, 32'h8,  1, 32'h4});
    vt.push_back('{0, 0, 1, 1, 1, 32'hC,  0, 32'h0});
    vt.push_back('{0, 0, 1, 1, 0, 32'h10, 1, 32'h8});
    vt.push_back('{0, 0, 1, 1, 1, 32'h10, 1, 32'hC});
    vt.push_back('{1, 0, 1, 1, 0, 32'h0,  0, 32'h0});
    vt.push_back('{0, 1, 1, 1, 1, 32'h0,  0, 32'h0});
    vt.push_back('{0, 1, 1, 1, 1, 32'h4,  0, 32'h0});
    vt.push_back('{0, 1, 1, 1, 0, 32'h8,  1, 32'h0});
    vt.push_back('{0, 1, 1, 1, 0, 32'h8,  1, 32'h0});
    vt.push_back('{0, 1, 1, 1, 0, 32'h8,  1, 32'h0});
    vt.push_back('{0, 0, 1, 1, 0, 32'h8,  1, 32'h0});
    vt.push_back('{0, 0, 1, 1, 1, 32'h8,  1, 32'h4});
    vt.push_back('{0, 0, 1, 1, 1, 32'hC,  0, 32'h0});
    vt.push_back('{0, 0, 1, 1, 0, 32'h10, 1, 32'h8});
    vt.push_back('{0, 0, 1, 1, 1, 32'h10, 1, 32'hC});

    foreach (vt[i]) begin
      step(vt[i].rst, vt[i].stall, 1'b0, 32'h0, vt[i].gnt, vt[i].rv, 1'b0);
      check($sformatf("tbl%0d.req", i), 32'(s_req), 32'(vt[i].e_req));
      if (!vt[i].rst) check($sformatf("tbl%0d.addr", i), s_addr, vt[i].e_addr);
      check($sformatf("tbl%0d.valid", i), 32'(s_valid), 32'(vt[i].e_valid));
      check($sformatf("tbl%0d.pc", i), s_pc, vt[i].e_pc);
      check($sformatf("tbl%0d.instr", i), s_instr, vt[i].e_valid ? mem_word(vt[i].e_pc) : NOP);
      check($sformatf("tbl%0d.flush", i), 32'(s_flush), 32'd0);
    end

    // Redirect with 0x8/0xC outstanding to an unaligned target.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      check_model("t3.pre");
    end
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check_model("t3.fill");
    check("t3.fill_addr", s_addr, 32'hC);
    step(1'b0, 1'b0, 1'b1, 32'h103, 1'b1, 1'b0, 1'b0);
    check_model("t3.redir");
    check("t3.flush", 32'(s_flush), 32'd1);
    run_after_redirect("t3", 32'h100, 16);

    // Redirect coinciding with a grant and a response.
    do_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    check_model("t4.pre");
    step(1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 1'b0);
    check_model("t4.redir");
    check("t4.issue_in_redirect", 32'(s_req), 32'd1);
    check("t4.flush", 32'(s_flush), 32'd1);
    run_after_redirect("t4", 32'h40, 16);

    // Back-to-back redirects while draining.
    do_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check_model("t5.a");
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check_model("t5.b");
    step(1'b0, 1'b0, 1'b1, 32'h180, 1'b1, 1'b0, 1'b0);
    check_model("t5.redir1");
    step(1'b0, 1'b1, 1'b1, 32'h200, 1'b1, 1'b1, 1'b0);
    check_model("t5.redir2");
    check("t5.flush2", 32'(s_flush), 32'd1);
    run_after_redirect("t5", 32'h200, 20);

    // Spurious rvalid when idle, then reset in the middle of a burst.
    do_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    check_model("t6.spur");
    check("t6.spur_valid", 32'(s_valid), 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    check_model("t6.spur2");
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      check_model("t6.burst");
    end
    step(1'b1, 1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 1'b0);
    check("t6.rst_req", 32'(s_req), 32'd0);
    check("t6.rst_valid", 32'(s_valid), 32'd0);
    check("t6.rst_flush", 32'(s_flush), 32'd0);
    check("t6.rst_instr", s_instr, NOP);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_model("t6.post");
    check("t6.post_addr", s_addr, RST_PC);
    check("t6.post_valid", 32'(s_valid), 32'd0);
    run_after_redirect("t6", RST_PC, 10);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 9) < 3,
           $urandom_range(0, 19) == 0,
           $urandom,
           $urandom_range(0, 9) < 6,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) == 0);
      check_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
